uart_packet_serializer: RTL and testbench

Streams a wide encoded packet (e.g. the 144-bit slave command) one byte at a time into a `uart_tx` instance. It sits between the packet encoders and the BLE/host UART transmitters, replacing hand-sequenced load/transmit states in the top-level FSM. It handles the `load_data`/`start_transmit`/`tx_finish` handshake, stretches strobes for the slower baud clock, and reports completion or timeout.

---
 rtl/uart_packet_serializer.sv | 202 ++++++++++++++++++++
 tb/tb_uart_packet_serializer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_serializer.sv
// Streams a wide packet one byte at a time into a uart_tx. It runs the load/start/finish
// handshake, stretches the strobes across the slow baud clock, and flags done or timeout.
module uart_packet_serializer #(
    parameter int PACKET_BITS = 144,
    parameter int HOLD_CYCLES = 5209,
    parameter int TIMEOUT     = 4000000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   soft_reset,
    input  logic                   start,
    input  logic [PACKET_BITS-1:0] packet_in,
    input  logic [7:0]             byte_count,
    input  logic                   uart_tx_done,
    output logic [7:0]             uart_data,
    output logic                   uart_load,
    output logic                   uart_start,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    localparam int                PACKET_BYTES = PACKET_BITS / 8;
    localparam int                HOLD_W       = $clog2(HOLD_CYCLES + 1);
    localparam logic [8:0]        MAX_COUNT    = 9'(PACKET_BYTES);
    localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [31:0]       TIMEOUT_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_READY,
        S_LOAD,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [PACKET_BITS-1:0]   packet_q;
    logic [7:0]               count_q;
    logic [7:0]               idx_q;
    logic [7:0]               idx_d;
    logic [7:0]               data_d;
    logic [HOLD_W-1:0]        hold_cnt_q;
    logic [31:0]              tmo_cnt_q;
    logic                     tx_done_meta;
    logic                     tx_done_sync;
    logic                     capture;
    logic                     done_d;
    logic                     error_d;
    logic                     hold_last;
    logic                     tmo_last;
    logic                     in_wait;

    function automatic logic [7:0] select_byte(input logic [PACKET_BITS-1:0] pkt,
                                               input logic [7:0]             index);
        logic [7:0] b;
        b = '0;
        for (int k = 0; k < PACKET_BYTES; k++) begin
            if (index == 8'(k)) b = pkt[8*k +: 8];
        end
        return b;
    endfunction

    // tx_finish comes from the baud domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_done_meta <= 1'b0;
            tx_done_sync <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make both flops sample old values on the
            // same edge, so this really is a two-stage chain and not a single wire.
            tx_done_meta <= uart_tx_done;
            tx_done_sync <= tx_done_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    assign hold_last = (hold_cnt_q == HOLD_LAST);
    assign tmo_last  = (tmo_cnt_q == TIMEOUT_LAST);
    assign in_wait   = (state_q == S_WAIT_READY) || (state_q == S_WAIT_BUSY) ||
                       (state_q == S_WAIT_DONE);

    always_comb begin
        // NOTE: every signal gets a default before the case. Any path that leaves a
        // signal unassigned would infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = uart_data;
        capture = 1'b0;
        done_d  = 1'b0;
        error_d = 1'b0;

        if (soft_reset) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (byte_count == 8'd0 || {1'b0, byte_count} > MAX_COUNT) begin
                            error_d = 1'b1;
                        end else begin
                            capture = 1'b1;
                            idx_d   = '0;
                            state_d = S_WAIT_READY;
                        end
                    end
                end
                S_WAIT_READY: begin
                    if (tx_done_sync) begin
                        data_d  = select_byte(packet_q, idx_q);
                        state_d = S_LOAD;
                    end else if (tmo_last) begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (hold_last) state_d = S_START;
                end
                S_START: begin
                    if (hold_last) state_d = S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!tx_done_sync) begin
                        state_d = S_WAIT_DONE;
                    end else if (tmo_last) begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_WAIT_DONE: begin
                    if (tx_done_sync) begin
                        if (idx_q == count_q - 8'd1) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            // The transmitter is already idle, so skip WAIT_READY.
                            idx_d   = idx_q + 8'd1;
                            data_d  = select_byte(packet_q, idx_q + 8'd1);
                            state_d = S_LOAD;
                        end
                    end else if (tmo_last) begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Both counters restart on every state change, so each state sees a fresh budget.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else if (state_d != state_q) begin
            hold_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            if (state_q == S_LOAD || state_q == S_START) hold_cnt_q <= hold_cnt_q + 1'b1;
            if (in_wait)                                 tmo_cnt_q  <= tmo_cnt_q + 32'd1;
        end
    end

    // NOTE: the packet and count registers have no reset. They are only read after
    // capture has loaded them, so a reset would only add fan-out on reset_n.
    always_ff @(posedge clk) begin
        if (capture) begin
            packet_q <= packet_in;
            count_q  <= byte_count;
        end
    end

    // Outputs are decoded from the next state, so every strobe is a flop output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q      <= '0;
            uart_data  <= '0;
            uart_load  <= 1'b0;
            uart_start <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            uart_data  <= data_d;
            uart_load  <= (state_d == S_LOAD);
            uart_start <= (state_d == S_START);
            busy       <= (state_d != S_IDLE);
            done       <= done_d;
            error      <= error_d;
        end
    end

endmodule

// File: tb/tb_uart_packet_serializer.sv
// Directed bench for uart_packet_serializer. A behavioural uart_tx stays busy for 10 cycles
// per byte. The bench checks byte order, strobe widths, done/error pulses, abort and reset.
module tb_uart_packet_serializer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        soft_reset;
    logic        start;
    logic [31:0] packet_in;
    logic [7:0]  byte_count;
    logic        uart_tx_done;
    logic [7:0]  uart_data;
    logic        uart_load;
    logic        uart_start;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    uart_packet_serializer #(
        .PACKET_BITS(32),
        .HOLD_CYCLES(2),
        .TIMEOUT    (50)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .soft_reset  (soft_reset),
        .start       (start),
        .packet_in   (packet_in),
        .byte_count  (byte_count),
        .uart_tx_done(uart_tx_done),
        .uart_data   (uart_data),
        .uart_load   (uart_load),
        .uart_start  (uart_start),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    // Transmitter model: captures on load, goes busy for 10 cycles after start.
    logic       tx_model = 1'b1;
    logic       stuck    = 1'b0;
    logic [7:0] model_buf = '0;
    int         busy_left = 0;
    logic [7:0] sent_q[$];

    assign uart_tx_done = stuck ? 1'b0 : tx_model;

    always @(negedge clk) begin
        if (uart_load) model_buf = uart_data;
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) tx_model = 1'b1;
        end else if (uart_start && tx_model) begin
            tx_model  = 1'b0;
            busy_left = 10;
            sent_q.push_back(model_buf);
        end
    end

    // Activity monitor: strobe widths, pulse counts, overlap.
    int load_run = 0, start_run = 0;
    int load_w[$];
    int start_w[$];
    int done_cnt = 0, err_cnt = 0, overlap_cnt = 0, strobe_cnt = 0, busy_cnt = 0;

    always @(negedge clk) begin
        if (uart_load) load_run++;
        else if (load_run != 0) begin load_w.push_back(load_run); load_run = 0; end
        if (uart_start) start_run++;
        else if (start_run != 0) begin start_w.push_back(start_run); start_run = 0; end
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (uart_load && uart_start) overlap_cnt++;
        if (uart_load || uart_start) strobe_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        sent_q.delete();
        load_w.delete();
        start_w.delete();
        load_run = 0; start_run = 0;
        done_cnt = 0; err_cnt = 0; overlap_cnt = 0; strobe_cnt = 0; busy_cnt = 0;
    endtask

    task automatic pulse_start(input logic [31:0] pkt, input logic [7:0] cnt);
        packet_in  = pkt;
        byte_count = cnt;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, done, 1'b1);
    endtask

    task automatic check_bytes(input string tag, input logic [31:0] pkt);
        logic [31:0] p;
        p = pkt;
        check({tag, "_n"}, sent_q.size(), 4);
        for (int i = 0; i < 4 && i < sent_q.size(); i++)
            check($sformatf("%s_b%0d", tag, i), sent_q[i], p[8*i +: 8]);
    endtask

    initial begin
        int cyc;
        int rises;
        logic prev;

        reset_n = 1'b0; soft_reset = 1'b0; start = 1'b0;
        packet_in = '0; byte_count = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",  busy,       1'b0);
        check("rst_load",  uart_load,  1'b0);
        check("rst_start", uart_start, 1'b0);
        check("rst_data",  uart_data,  8'h00);
        check("rst_done",  done,       1'b0);
        check("rst_error", error,      1'b0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Full packet.
        clear_mon();
        pulse_start(32'hDEADBEEF, 8'd4);
        check("full_busy", busy, 1'b1);
        wait_done("full_done_seen", 400);
        repeat (5) @(negedge clk);
        check_bytes("full", 32'hDEADBEEF);
        check("full_nload", load_w.size(), 4);
        foreach (load_w[i])  check($sformatf("full_loadw%0d", i),  load_w[i],  2);
        foreach (start_w[i]) check($sformatf("full_startw%0d", i), start_w[i], 2);
        check("full_done_cnt", done_cnt, 1);
        check("full_err_cnt",  err_cnt,  0);
        check("full_overlap",  overlap_cnt, 0);

        // Partial packet: a single byte.
        clear_mon();
        pulse_start(32'hDEADBEEF, 8'd1);
        wait_done("part_done_seen", 200);
        check("part_busy_at_done", busy, 1'b0);
        repeat (5) @(negedge clk);
        check("part_n", sent_q.size(), 1);
        if (sent_q.size() > 0) check("part_b0", sent_q[0], 8'hEF);
        check("part_done_cnt", done_cnt, 1);
        check("part_busy_end", busy, 1'b0);

        // Bad lengths.
        clear_mon();
        pulse_start(32'hDEADBEEF, 8'd0);
        check("bad0_error", error, 1'b1);
        check("bad0_busy",  busy,  1'b0);
        repeat (3) @(negedge clk);
        pulse_start(32'hDEADBEEF, 8'd5);
        check("bad5_error", error, 1'b1);
        repeat (5) @(negedge clk);
        check("bad_err_cnt",  err_cnt,    2);
        check("bad_busy_cnt", busy_cnt,   0);
        check("bad_strobes",  strobe_cnt, 0);

        // Stuck transmitter: timeout in WAIT_READY.
        stuck = 1'b1;
        repeat (4) @(negedge clk);
        clear_mon();
        pulse_start(32'hDEADBEEF, 8'd4);
        cyc = 0;
        while (!error && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("tmo_latency", cyc, 50);
        check("tmo_busy", busy, 1'b0);
        repeat (5) @(negedge clk);
        check("tmo_done_cnt", done_cnt,   0);
        check("tmo_err_cnt",  err_cnt,    1);
        check("tmo_strobes",  strobe_cnt, 0);
        stuck = 1'b0;
        repeat (5) @(negedge clk);

        // Abort during the second byte's START.
        clear_mon();
        pulse_start(32'hDEADBEEF, 8'd4);
        rises = 0; prev = 1'b0; cyc = 0;
        while (rises < 2 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (uart_start && !prev) rises++;
            prev = uart_start;
        end
        check("abort_reached_start2", rises, 2);
        soft_reset = 1'b1;
        @(negedge clk);
        soft_reset = 1'b0;
        check("abort_busy",  busy,       1'b0);
        check("abort_load",  uart_load,  1'b0);
        check("abort_start", uart_start, 1'b0);
        check("abort_done",  done,       1'b0);
        check("abort_error", error,      1'b0);
        repeat (30) @(negedge clk);
        check("abort_done_cnt", done_cnt, 0);
        check("abort_err_cnt",  err_cnt,  0);
        // A start that coincides with soft_reset must be ignored.
        soft_reset = 1'b1;
        pulse_start(32'h01020304, 8'd4);
        soft_reset = 1'b0;
        @(negedge clk);
        check("sr_start_ignored", busy, 1'b0);
        clear_mon();
        pulse_start(32'h01020304, 8'd4);
        wait_done("abort_rerun_done", 400);
        repeat (5) @(negedge clk);
        check_bytes("rerun", 32'h01020304);

        // A start while busy must not disturb the latched packet.
        clear_mon();
        pulse_start(32'hDEADBEEF, 8'd4);
        repeat (8) @(negedge clk);
        pulse_start(32'h11223344, 8'd2);
        wait_done("ign_done_seen", 400);
        repeat (5) @(negedge clk);
        check_bytes("ign", 32'hDEADBEEF);
        check("ign_done_cnt", done_cnt, 1);

        // Asynchronous reset in the middle of LOAD.
        clear_mon();
        pulse_start(32'h0000A55A, 8'd2);
        cyc = 0;
        while (!uart_load && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid_in_load", uart_load, 1'b1);
        reset_n = 1'b0;
        #1;
        check("arst_load",  uart_load,  1'b0);
        check("arst_busy",  busy,       1'b0);
        check("arst_data",  uart_data,  8'h00);
        check("arst_start", uart_start, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        clear_mon();
        pulse_start(32'h0000A55A, 8'd2);
        wait_done("post_rst_done", 200);
        repeat (5) @(negedge clk);
        check("post_rst_n", sent_q.size(), 2);
        if (sent_q.size() == 2) begin
            check("post_rst_b0", sent_q[0], 8'h5A);
            check("post_rst_b1", sent_q[1], 8'hA5);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
